pcs_rx_block_lock: RTL and testbench
====================================

Name: pcs_rx_block_lock

Overview:
- Receive-side 64b/66b block synchronizer for the low-latency 10GBASE-R PCS. It is the counterpart of the TX 66-bit block encoder/gearbox path, which is exercised in GT serial loopback.
- Sits between the GT RX gearbox output (66-bit blocks at 156.25 MHz) and the RX descrambler/decoder.
- Hunts for sync-header alignment, drives a slip pulse to the GT, declares block lock, and forwards aligned blocks only while locked.

Parameters:
- SH_CNT_MAX, 64, headers per lock/monitor window.
- INVALID_MAX, 16, invalid headers in one window that cause loss of lock.
- SLIP_WAIT, 32, clk cycles to ignore input after a slip pulse (GT realignment settle time).
- BER_WINDOW, 19531, clk cycles per hi-BER window (125 us at 156.25 MHz); used only with the optional feature.
- BER_THRESH, 16, invalid headers per BER window that assert hi_ber; used only with the optional feature.

Ports:
- clk  input  1  PCS clock, 156.25 MHz, single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- rx_valid  input  1  block qualifier from the gearbox; may deassert for gearbox pause cycles.
- rx_header  input  2  sync header of the current block.
- rx_data  input  64  payload of the current block.
- rx_slip  output  1  one-cycle pulse requesting a 1-bit slip from the GT (RXSLIDE).
- block_lock  output  1  registered lock status.
- out_valid  output  1  aligned block valid.
- out_header  output  2  registered copy of rx_header.
- out_data  output  64  registered copy of rx_data.
- hi_ber  output  1  high bit-error-rate flag; present only when PCS_HI_BER_EN is defined.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=HUNT.
  - sh_cnt, sh_invalid_cnt and the slip-wait counter = 0.
  - rx_slip=0, block_lock=0, out_valid=0, out_header=0, out_data=0, hi_ber=0.
  - Reset takes effect in any state. A reset arriving during SLIP_WAIT or LOCKED drops lock on the next edge.
- Header validity: a header is valid iff rx_header is 2'b01 or 2'b10. 2'b00 and 2'b11 are invalid.
- Counter width: $clog2(SH_CNT_MAX+1) bits. Counters never wrap; they are cleared explicitly.
- Datapath:
  - On every edge, out_header<=rx_header, out_data<=rx_data, out_valid<=rx_valid & block_lock (value before the edge).
  - Latency is 1 clk.
  - No backpressure.
- HUNT (block_lock=0): acts only on cycles with rx_valid=1.
  - Invalid header: rx_slip=1 for exactly one cycle, counters cleared, go to SLIP_WAIT.
  - Valid header: sh_cnt+1.
  - The SH_CNT_MAX-th consecutive valid header sets block_lock=1 on that edge, clears counters, and goes to LOCKED.
- SLIP_WAIT:
  - rx_valid, rx_header and rx_data are ignored for SLIP_WAIT cycles, counted whether or not rx_valid is high.
  - Then go to HUNT with counters cleared.
  - rx_slip is 0 throughout.
- LOCKED: acts only on cycles with rx_valid=1.
  - Each header increments sh_cnt; each invalid header also increments sh_invalid_cnt.
  - If the increment makes sh_invalid_cnt reach INVALID_MAX: block_lock=0 and a one-cycle rx_slip pulse on that edge, counters cleared, go to SLIP_WAIT.
  - Otherwise, if sh_cnt reaches SH_CNT_MAX: both counters cleared, stay LOCKED.
- Simultaneous events: the INVALID_MAX-th invalid header arriving on the SH_CNT_MAX-th header means loss of lock; loss of lock has priority over the window reset.
- rx_valid=0 cycles leave all counters and state unchanged, except the SLIP_WAIT counter.
- Consecutive slips are separated by at least SLIP_WAIT+1 cycles.

Optional Feature:
- Macro PCS_HI_BER_EN.
- Defined:
  - A free-running window counter counts 0..BER_WINDOW-1. A separate ber_cnt counts invalid headers while rx_valid=1, saturating at BER_THRESH.
  - At window end, hi_ber<=(ber_cnt>=BER_THRESH) and ber_cnt is cleared. If an invalid header arrives in the same cycle as window end, it counts toward the closing window.
  - hi_ber is independent of the lock state machine and resets to 0.
- Undefined: the hi_ber port, window counter and ber_cnt do not exist; behaviour is otherwise identical.

Test Plan:
- Clean lock: reset, then 64 blocks with header 01 and rx_valid=1 → block_lock=1 after the 64th edge; the 65th block appears on out_valid/out_data one cycle later; rx_slip never pulses.
- Misalignment: 10 valid headers, then header 11 → rx_slip high exactly 1 cycle; the next 32 inputs are ignored; hunt restarts with sh_cnt=0; lock is achieved only after 64 further consecutive valid headers.
- Tolerated errors in lock: once locked, 15 invalid headers spread across one 64-header window, repeated for 3 windows → block_lock stays 1 and rx_slip stays 0.
- Loss of lock: once locked, 16 invalid headers within one window → block_lock=0 on the 16th; rx_slip pulses on the same edge; out_valid=0 from the next cycle.
- Priority and gaps: locked, 15 invalid headers placed on headers 1..15, rx_valid toggled 1/0, and a 16th invalid on header 64 → lock lost (not a window reset); the idle cycles change no counters.
- Reset mid-operation and hi_ber: rst_n=0 for 1 cycle while LOCKED → all outputs 0 next cycle and state HUNT. With PCS_HI_BER_EN, BER_WINDOW=100 and 16 invalid headers in one window → hi_ber=1 at that window end; a clean next window → hi_ber=0.

Source files
------------

// File: rtl/pcs_rx_block_lock.sv
// ============================================================================
// Module   : pcs_rx_block_lock
// Purpose  : 10GBASE-R RX 64b/66b block synchronizer. It hunts for sync-header
//            alignment, slips the GT, declares lock and forwards aligned blocks.
//            Optional hi-BER monitor: define PCS_HI_BER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcs_rx_block_lock #(
    parameter int SH_CNT_MAX  = 64,
    parameter int INVALID_MAX = 16,
    parameter int SLIP_WAIT   = 32
`ifdef PCS_HI_BER_EN
    ,
    parameter int BER_WINDOW  = 19531,
    parameter int BER_THRESH  = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [1:0]  rx_header,
    input  logic [63:0] rx_data,
    output logic        rx_slip,
    output logic        block_lock,
    output logic        out_valid,
    output logic [1:0]  out_header,
    output logic [63:0] out_data
`ifdef PCS_HI_BER_EN
    ,
    output logic        hi_ber
`endif
);

    localparam int CW = $clog2(SH_CNT_MAX + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam logic [CW-1:0] C_SH_LAST   = CW'(SH_CNT_MAX - 1);
    localparam logic [CW-1:0] C_INV_LAST  = CW'(INVALID_MAX - 1);
    localparam logic [WW-1:0] C_WAIT_LAST = WW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_sh_cnt;
    logic [CW-1:0] w_sh_cnt_nxt;
    logic [CW-1:0] r_inv_cnt;
    logic [CW-1:0] w_inv_cnt_nxt;
    logic [WW-1:0] r_wait_cnt;
    logic [WW-1:0] w_wait_cnt_nxt;
    logic          w_slip_nxt;
    logic          w_lock_nxt;
    logic          w_hdr_ok;

    // Only 01 and 10 are legal sync headers.
    assign w_hdr_ok = rx_header[1] ^ rx_header[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_sh_cnt   <= '0;
            r_inv_cnt  <= '0;
            r_wait_cnt <= '0;
            rx_slip    <= 1'b0;
            block_lock <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sh_cnt   <= w_sh_cnt_nxt;
            r_inv_cnt  <= w_inv_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            rx_slip    <= w_slip_nxt;
            block_lock <= w_lock_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sh_cnt_nxt   = r_sh_cnt;
        w_inv_cnt_nxt  = r_inv_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_slip_nxt     = 1'b0;
        w_lock_nxt     = block_lock;

        case (r_state)
            ST_HUNT: begin
                w_lock_nxt = 1'b0;
                if (rx_valid) begin
                    if (!w_hdr_ok) begin
                        w_slip_nxt     = 1'b1;
                        w_sh_cnt_nxt   = '0;
                        w_inv_cnt_nxt  = '0;
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = ST_SLIP_WAIT;
                    end else if (r_sh_cnt == C_SH_LAST) begin
                        w_lock_nxt    = 1'b1;
                        w_sh_cnt_nxt  = '0;
                        w_inv_cnt_nxt = '0;
                        w_state_nxt   = ST_LOCKED;
                    end else begin
                        w_sh_cnt_nxt = r_sh_cnt + 1'b1;
                    end
                end
            end

            // Counts every cycle, valid or not, so the GT has time to settle.
            ST_SLIP_WAIT: begin
                w_lock_nxt = 1'b0;
                if (r_wait_cnt == C_WAIT_LAST) begin
                    w_wait_cnt_nxt = '0;
                    w_sh_cnt_nxt   = '0;
                    w_inv_cnt_nxt  = '0;
                    w_state_nxt    = ST_HUNT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end

            ST_LOCKED: begin
                w_lock_nxt = 1'b1;
                if (rx_valid) begin
                    w_sh_cnt_nxt = r_sh_cnt + 1'b1;
                    if (!w_hdr_ok) begin
                        w_inv_cnt_nxt = r_inv_cnt + 1'b1;
                    end
                    // Loss of lock wins over the end-of-window clear.
                    if (!w_hdr_ok && (r_inv_cnt == C_INV_LAST)) begin
                        w_lock_nxt     = 1'b0;
                        w_slip_nxt     = 1'b1;
                        w_sh_cnt_nxt   = '0;
                        w_inv_cnt_nxt  = '0;
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = ST_SLIP_WAIT;
                    end else if (r_sh_cnt == C_SH_LAST) begin
                        w_sh_cnt_nxt  = '0;
                        w_inv_cnt_nxt = '0;
                    end
                end
            end

            default: begin
                w_lock_nxt     = 1'b0;
                w_sh_cnt_nxt   = '0;
                w_inv_cnt_nxt  = '0;
                w_wait_cnt_nxt = '0;
                w_state_nxt    = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_header <= 2'b00;
            out_data   <= 64'd0;
        end else begin
            out_valid  <= rx_valid & block_lock;
            out_header <= rx_header;
            out_data   <= rx_data;
        end
    end

`ifdef PCS_HI_BER_EN
    localparam int BWW = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;
    localparam int BCW = $clog2(BER_THRESH + 1);
    localparam logic [BWW-1:0] C_WIN_LAST   = BWW'(BER_WINDOW - 1);
    localparam logic [BCW-1:0] C_BER_THRESH = BCW'(BER_THRESH);

    logic [BWW-1:0] r_win_cnt;
    logic [BCW-1:0] r_ber_cnt;
    logic [BCW-1:0] w_ber_sum;
    logic           w_ber_inc;

    // Saturating sum including the current header, so a window-end hit counts.
    assign w_ber_inc = rx_valid & ~w_hdr_ok & (r_ber_cnt != C_BER_THRESH);
    assign w_ber_sum = r_ber_cnt + BCW'(w_ber_inc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
            r_ber_cnt <= '0;
            hi_ber    <= 1'b0;
        end else if (r_win_cnt == C_WIN_LAST) begin
            r_win_cnt <= '0;
            r_ber_cnt <= '0;
            hi_ber    <= (w_ber_sum >= C_BER_THRESH);
        end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
            r_ber_cnt <= w_ber_sum;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcs_rx_block_lock.sv
// ============================================================================
// Module   : tb_pcs_rx_block_lock
// Purpose  : Directed self-checking bench for pcs_rx_block_lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcs_rx_block_lock;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [1:0]  rx_header;
    logic [63:0] rx_data;
    logic        rx_slip;
    logic        block_lock;
    logic        out_valid;
    logic [1:0]  out_header;
    logic [63:0] out_data;
`ifdef PCS_HI_BER_EN
    logic        hi_ber;
`endif

    int          vectors;
    int          miscompares;
    int          slips;
    int          ncyc;
    logic [63:0] last_data;

    pcs_rx_block_lock #(
        .SH_CNT_MAX (64),
        .INVALID_MAX(16),
        .SLIP_WAIT  (32)
`ifdef PCS_HI_BER_EN
        ,
        .BER_WINDOW (100),
        .BER_THRESH (16)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_header (rx_header),
        .rx_data   (rx_data),
        .rx_slip   (rx_slip),
        .block_lock(block_lock),
        .out_valid (out_valid),
        .out_header(out_header),
        .out_data  (out_data)
`ifdef PCS_HI_BER_EN
        ,
        .hi_ber    (hi_ber)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input vector across one rising edge; outputs settle 1 ns later.
    task automatic cyc(input logic v, input logic [1:0] h);
        ncyc      = ncyc + 1;
        rx_valid  = v;
        rx_header = h;
        rx_data   = {32'(ncyc) ^ 32'hA5A5_0000, ~32'(ncyc)};
        last_data = rx_data;
        @(posedge clk);
        #1;
        if (rx_slip) slips = slips + 1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors = vectors + 1;
        assert (obs === exp)
        else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic valid_run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 2'b01);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        slips       = 0;
        ncyc        = 0;
        last_data   = '0;
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_header   = 2'b00;
        rx_data     = '0;

        // Reset with live input: everything must read zero.
        cyc(1'b1, 2'b10);
        cyc(1'b1, 2'b10);
        check("rst_lock",   64'(block_lock), 64'd0);
        check("rst_slip",   64'(rx_slip),    64'd0);
        check("rst_oval",   64'(out_valid),  64'd0);
        check("rst_ohdr",   64'(out_header), 64'd0);
        check("rst_odata",  out_data,        64'd0);

        // Clean lock after exactly 64 valid headers.
        rst_n = 1'b1;
        slips = 0;
        valid_run(63);
        check("lock_at63",  64'(block_lock), 64'd0);
        cyc(1'b1, 2'b01);
        check("lock_at64",  64'(block_lock), 64'd1);
        check("oval_at64",  64'(out_valid),  64'd0);
        cyc(1'b1, 2'b10);
        check("oval_65",    64'(out_valid),  64'd1);
        check("odata_65",   out_data,        last_data);
        check("ohdr_65",    64'(out_header), 64'd2);
        check("clean_slips", 64'(slips),     64'd0);

        // Misalignment: slip on the 11th header, 32 ignored inputs, then relock.
        rst_n = 1'b0;
        cyc(1'b1, 2'b01);
        rst_n = 1'b1;
        slips = 0;
        valid_run(10);
        cyc(1'b1, 2'b11);
        check("mis_slip",   64'(rx_slip),    64'd1);
        check("mis_lock",   64'(block_lock), 64'd0);
        cyc(1'b1, 2'b00);
        check("mis_slip_1cyc", 64'(rx_slip), 64'd0);
        for (int i = 1; i < 31; i++) cyc(1'((i % 3) != 0), (i % 2 == 0) ? 2'b00 : 2'b11);
        cyc(1'b1, 2'b11);
        check("mis_ignored", 64'(slips),     64'd1);
        valid_run(63);
        check("mis_relock63", 64'(block_lock), 64'd0);
        cyc(1'b1, 2'b01);
        check("mis_relock64", 64'(block_lock), 64'd1);

        // Three windows each with 15 invalid headers: lock must hold.
        slips = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 64; i++)
                cyc(1'b1, ((i % 4 == 0) && (i < 60)) ? 2'b00 : 2'b01);
            check("tol_lock", 64'(block_lock), 64'd1);
        end
        check("tol_slips",  64'(slips),      64'd0);

        // 16 invalid headers on even positions: lost on position 30.
        for (int i = 0; i < 30; i++) cyc(1'b1, (i % 2 == 0) ? 2'b11 : 2'b01);
        check("lol_before", 64'(block_lock), 64'd1);
        cyc(1'b1, 2'b11);
        check("lol_lock",   64'(block_lock), 64'd0);
        check("lol_slip",   64'(rx_slip),    64'd1);
        check("lol_oval_edge", 64'(out_valid), 64'd1);
        cyc(1'b1, 2'b01);
        check("lol_oval_next", 64'(out_valid), 64'd0);
        check("lol_slip_next", 64'(rx_slip),   64'd0);
        valid_run(31 + 64);
        check("lol_relock", 64'(block_lock), 64'd1);

        // Priority with gaps: 15 invalid with idle cycles, 16th on header 64.
        slips = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 2'b11);
            cyc(1'b0, 2'b00);
        end
        check("gap_oval_idle", 64'(out_valid), 64'd0);
        valid_run(48);
        check("gap_lock63", 64'(block_lock), 64'd1);
        check("gap_slips",  64'(slips),      64'd0);
        cyc(1'b1, 2'b00);
        check("gap_lock64", 64'(block_lock), 64'd0);
        check("gap_slip64", 64'(rx_slip),    64'd1);
        valid_run(32 + 64);
        check("gap_relock", 64'(block_lock), 64'd1);

        // Reset while locked returns to a fresh hunt.
        rst_n = 1'b0;
        cyc(1'b1, 2'b10);
        check("mid_rst_lock", 64'(block_lock), 64'd0);
        check("mid_rst_oval", 64'(out_valid),  64'd0);
        check("mid_rst_odat", out_data,        64'd0);
        check("mid_rst_slip", 64'(rx_slip),    64'd0);
        rst_n = 1'b1;
        valid_run(63);
        check("mid_hunt63", 64'(block_lock), 64'd0);
        cyc(1'b1, 2'b01);
        check("mid_hunt64", 64'(block_lock), 64'd1);

`ifdef PCS_HI_BER_EN
        // Window of 100 cycles starting at reset: 16 errors then a clean window.
        rst_n = 1'b0;
        cyc(1'b0, 2'b01);
        rst_n = 1'b1;
        for (int k = 1; k < 100; k++) cyc(1'b1, (k <= 16) ? 2'b11 : 2'b01);
        check("ber_pre_end",  64'(hi_ber), 64'd0);
        cyc(1'b1, 2'b01);
        check("ber_end1",     64'(hi_ber), 64'd1);
        valid_run(99);
        check("ber_hold",     64'(hi_ber), 64'd1);
        cyc(1'b1, 2'b01);
        check("ber_end2",     64'(hi_ber), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
